// File: rtl/alu_rr_sched_if.sv
// Bundle of the two requester channels, the shared response channel and the ALU operand/result port.
// slave = scheduler side; master = requesters, response consumer and ALU side.
interface alu_rr_sched_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;

  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_i0;
  logic [WIDTH-1:0] alu_i1;
  logic [WIDTH-1:0] alu_o;
  logic             alu_cout;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, alu_o, alu_cout,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_cout,
    output alu_op, alu_i0, alu_i1
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_o, alu_cout,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout,
    input  alu_op, alu_i0, alu_i1
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; ALU_STATS_EN adds op/stall counters.
// Latency: response valid two cycles after the accept cycle; one op per 3 cycles at best.
// Backpressure: response held stable until rsp_ready; no request accepted while busy.
module alu_rr_sched #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2,
  parameter int STATW = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_rr_sched_if.slave      bus
`ifdef ALU_STATS_EN
  ,
  output logic [STATW-1:0]   stat_ops0,
  output logic [STATW-1:0]   stat_ops1,
  output logic [STATW-1:0]   stat_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_i0;
  logic [WIDTH-1:0] r_i1;
  logic             r_id;
  logic [WIDTH-1:0] r_data;
  logic             r_cout;

  logic w_idle;
  logic w_g0;
  logic w_g1;
  logic w_rdy0;
  logic w_rdy1;
  logic w_acc;

  // On a tie the requester that did not win last time gets the grant.
  assign w_idle = (r_state == S_IDLE) && !reset;
  assign w_g0   = bus.req0_valid && (!bus.req1_valid || r_last);
  assign w_g1   = bus.req1_valid && (!bus.req0_valid || !r_last);
  assign w_rdy0 = w_idle && w_g0;
  assign w_rdy1 = w_idle && w_g1;
  assign w_acc  = w_rdy0 || w_rdy1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
      r_op   <= '0;
      r_i0   <= '0;
      r_i1   <= '0;
      r_id   <= 1'b0;
      r_data <= '0;
      r_cout <= 1'b0;
    end else begin
      if (w_acc) begin
        r_op   <= w_g1 ? bus.req1_op : bus.req0_op;
        r_i0   <= w_g1 ? bus.req1_a  : bus.req0_a;
        r_i1   <= w_g1 ? bus.req1_b  : bus.req0_b;
        r_id   <= w_g1;
        r_last <= w_g1;
      end
      if (r_state == S_EXEC) begin
        r_data <= bus.alu_o;
        r_cout <= bus.alu_cout;
      end
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_data   = r_data;
  assign bus.rsp_cout   = r_cout;
  assign bus.alu_op     = r_op;
  assign bus.alu_i0     = r_i0;
  assign bus.alu_i1     = r_i1;

`ifdef ALU_STATS_EN
  localparam logic [STATW-1:0] STAT_MAX = '1;

  logic [STATW-1:0] r_ops0;
  logic [STATW-1:0] r_ops1;
  logic [STATW-1:0] r_stall;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ops0  <= '0;
      r_ops1  <= '0;
      r_stall <= '0;
    end else begin
      if (w_rdy0 && (r_ops0 != STAT_MAX)) r_ops0 <= r_ops0 + 1'b1;
      if (w_rdy1 && (r_ops1 != STAT_MAX)) r_ops1 <= r_ops1 + 1'b1;
      if ((r_state == S_RESP) && !bus.rsp_ready && (r_stall != STAT_MAX))
        r_stall <= r_stall + 1'b1;
    end
  end

  assign stat_ops0  = r_ops0;
  assign stat_ops1  = r_ops1;
  assign stat_stall = r_stall;
`else
  logic w_unused_statw;
  assign w_unused_statw = (STATW > 0);
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Randomized bench for alu_rr_sched against a transaction-level reference model; build with ALU_STATS_EN to cover the counters.
module tb_alu_rr_sched;
  localparam int TB_STATW = 3;
  localparam int STAT_MAX = (1 << TB_STATW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_rr_sched_if #(.WIDTH(16), .OPW(2)) bus ();

`ifdef ALU_STATS_EN
  logic [TB_STATW-1:0] stat_ops0, stat_ops1, stat_stall;
`endif

  alu_rr_sched #(.WIDTH(16), .OPW(2), .STATW(TB_STATW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_STATS_EN
    ,
    .stat_ops0  (stat_ops0),
    .stat_ops1  (stat_ops1),
    .stat_stall (stat_stall)
`endif
  );

  // 00 add, 01 subtract (cout = borrow), 10 and, 11 xor
  function automatic logic [16:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always_comb {bus.alu_cout, bus.alu_o} = alu_ref(bus.alu_op, bus.alu_i0, bus.alu_i1);

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus state
  logic        d_v0 = 0, d_v1 = 0, d_rr = 1;
  logic [1:0]  d_op0 = 0, d_op1 = 0;
  logic [15:0] d_a0 = 0, d_b0 = 0, d_a1 = 0, d_b1 = 0;

  // reference model: one outstanding op, response appears two cycles after its accept cycle
  bit          m_pending = 0;
  int          m_age = 0;
  bit          m_last = 1;
  logic [1:0]  m_aop = 0;
  logic [15:0] m_ai0 = 0, m_ai1 = 0;
  logic [16:0] m_exp = 0;
  bit          m_id = 0;
  int          m_ops0 = 0, m_ops1 = 0, m_stall = 0;
  int          gseq[$];

  task automatic model_reset();
    m_pending = 0; m_age = 0; m_last = 1;
    m_aop = 0; m_ai0 = 0; m_ai1 = 0;
    m_ops0 = 0; m_ops1 = 0; m_stall = 0;
  endtask

  task automatic check_cycle();
    bit e0, e1;
    if (m_pending) m_age++;
`ifdef ALU_STATS_EN
    chk("stat_ops0", 32'(stat_ops0), m_ops0);
    chk("stat_ops1", 32'(stat_ops1), m_ops1);
    chk("stat_stall", 32'(stat_stall), m_stall);
`endif
    chk("alu_op", 32'(bus.alu_op), 32'(m_aop));
    chk("alu_i0", 32'(bus.alu_i0), 32'(m_ai0));
    chk("alu_i1", 32'(bus.alu_i1), 32'(m_ai1));
    if (!m_pending) begin
      e0 = d_v0 && (!d_v1 || m_last);
      e1 = d_v1 && (!d_v0 || !m_last);
      chk("idle_rdy0", 32'(bus.req0_ready), 32'(e0));
      chk("idle_rdy1", 32'(bus.req1_ready), 32'(e1));
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
      if (e0 || e1) begin
        m_pending = 1; m_age = 0; m_last = e1; m_id = e1;
        m_aop = e1 ? d_op1 : d_op0;
        m_ai0 = e1 ? d_a1 : d_a0;
        m_ai1 = e1 ? d_b1 : d_b0;
        m_exp = alu_ref(m_aop, m_ai0, m_ai1);
        if (e1) begin if (m_ops1 < STAT_MAX) m_ops1++; end
        else    begin if (m_ops0 < STAT_MAX) m_ops0++; end
      end
    end else begin
      chk("busy_rdy0", 32'(bus.req0_ready), 0);
      chk("busy_rdy1", 32'(bus.req1_ready), 0);
      if (m_age == 1) begin
        chk("exec_rsp_valid", 32'(bus.rsp_valid), 0);
      end else begin
        chk("rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("rsp_data", 32'(bus.rsp_data), 32'(m_exp[15:0]));
        chk("rsp_cout", 32'(bus.rsp_cout), 32'(m_exp[16]));
        if (d_rr) m_pending = 0;
        else if (m_stall < STAT_MAX) m_stall++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.req0_valid = d_v0; bus.req0_op = d_op0; bus.req0_a = d_a0; bus.req0_b = d_b0;
    bus.req1_valid = d_v1; bus.req1_op = d_op1; bus.req1_a = d_a1; bus.req1_b = d_b1;
    bus.rsp_ready  = d_rr;
    #1;
    check_cycle();
    if (bus.req0_ready || bus.req1_ready) gseq.push_back(int'(bus.req1_ready));
  endtask

  task automatic do_reset();
    bus.req0_valid = 1; bus.req1_valid = 1;
    reset = 1;
    #1;
    chk("rst_rdy0", 32'(bus.req0_ready), 0);
    chk("rst_rdy1", 32'(bus.req1_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_cout", 32'(bus.rsp_cout), 0);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    chk("rst_alu_i0", 32'(bus.alu_i0), 0);
    chk("rst_alu_i1", 32'(bus.alu_i1), 0);
`ifdef ALU_STATS_EN
    chk("rst_stat_ops0", 32'(stat_ops0), 0);
    chk("rst_stat_ops1", 32'(stat_ops1), 0);
    chk("rst_stat_stall", 32'(stat_stall), 0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    d_v0 = 0; d_v1 = 0;
    bus.req0_valid = 0; bus.req1_valid = 0;
    reset = 0;
  endtask

  task automatic drain();
    d_v0 = 0; d_v1 = 0; d_rr = 1;
    repeat (4) step();
  endtask

  initial begin
    bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready = 1;
    do_reset();

    // single requester 0, add without carry
    d_v0 = 1; d_op0 = 2'b00; d_a0 = 16'haa55; d_b0 = 16'h55aa; d_rr = 1;
    step();
    chk("t1_accept", 32'(bus.req0_ready), 1);
    d_v0 = 0;
    step();
    step();
    chk("t1_valid", 32'(bus.rsp_valid), 1);
    chk("t1_id", 32'(bus.rsp_id), 0);
    chk("t1_data", 32'(bus.rsp_data), 32'h0000ffff);
    chk("t1_cout", 32'(bus.rsp_cout), 0);
    step();

    // single requester 1, add with carry out
    d_v1 = 1; d_op1 = 2'b00; d_a1 = 16'hffff; d_b1 = 16'h0001;
    step();
    d_v1 = 0;
    step();
    chk("t2_alu_i0", 32'(bus.alu_i0), 32'h0000ffff);
    chk("t2_alu_i1", 32'(bus.alu_i1), 32'h00000001);
    step();
    chk("t2_id", 32'(bus.rsp_id), 1);
    chk("t2_data", 32'(bus.rsp_data), 0);
    chk("t2_cout", 32'(bus.rsp_cout), 1);
    step();

    // both requesters continuously valid: alternate grants
    gseq.delete();
    d_v0 = 1; d_v1 = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.req0_ready) begin d_op0 = 2'($urandom); d_a0 = 16'($urandom); d_b0 = 16'($urandom); end
      if (bus.req1_ready) begin d_op1 = 2'($urandom); d_a1 = 16'($urandom); d_b1 = 16'($urandom); end
    end
    chk("t3_grants", 32'(gseq.size()), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("t3_order", 32'(gseq[i]), 32'(i % 2));
    drain();

    // reset while the op is executing drops it
    d_v0 = 1; d_op0 = 2'b00; d_a0 = 16'h0001; d_b0 = 16'h7fff;
    step();
    d_v0 = 0;
    step();
    do_reset();
    d_v0 = 1; d_v1 = 1;
    step();
    chk("t5_tie_req0", 32'(bus.req0_ready), 1);
    drain();

    // held response: five stall cycles, then back-to-back grant after release
    d_v0 = 1; d_op0 = 2'($urandom); d_a0 = 16'($urandom); d_b0 = 16'($urandom); d_rr = 0;
    step();
    d_v0 = 0;
    d_v1 = 1; d_op1 = 2'b01; d_a1 = 16'h0003; d_b1 = 16'h0005;
    step();
    repeat (5) step();
    d_rr = 1;
    step();
    step();
    chk("t4_b2b_grant", 32'(bus.req1_ready), 1);
`ifdef ALU_STATS_EN
    chk("t4_stat_stall", 32'(stat_stall), 5);
`endif
    d_v1 = 0;
    drain();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (!d_v0 && $urandom_range(0, 2) != 0) begin
        d_v0 = 1; d_op0 = 2'($urandom); d_a0 = 16'($urandom); d_b0 = 16'($urandom);
      end
      if (!d_v1 && $urandom_range(0, 2) != 0) begin
        d_v1 = 1; d_op1 = 2'($urandom); d_a1 = 16'($urandom); d_b1 = 16'($urandom);
      end
      d_rr = ($urandom_range(0, 3) != 0);
      step();
      if (bus.req0_ready) d_v0 = 0;
      if (bus.req1_ready) d_v1 = 0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
